// File: rtl/aud_recorder.sv
// I2S left-channel recorder: captures one left sample per LR frame from the codec ADC
// stream and emits a one-cycle SRAM write strobe with an incrementing word address.
module aud_recorder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_valid,
  output logic              o_recording,
  output logic              o_full
);

  localparam int unsigned       CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitHigh,
    StWaitFall,
    StShift,
    StStore
  } state_e;

  state_e              state_q, state_d;
  logic                lrck_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                full_q, full_d;
  logic                lrck_fall;
  logic [DATA_W-1:0]   word;

  assign lrck_fall = lrck_q & ~i_adclrck;
  // Word including the bit arriving on this edge.
  assign word      = {shift_q[DATA_W-2:0], i_adcdat};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    full_d  = full_q;
    if ((state_q != StIdle) && i_stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start && !i_stop) begin
            addr_d  = '0;
            full_d  = 1'b0;
            state_d = StWaitHigh;
          end
        end
        StWaitHigh: begin
          if (i_adclrck) state_d = StWaitFall;
        end
        StWaitFall: begin
          // The falling edge itself is the I2S one-bit delay; its data bit is ignored.
          if (lrck_fall && !i_pause) begin
            cnt_d   = '0;
            state_d = StShift;
          end
        end
        StShift: begin
          shift_d = word;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            data_d  = word;
            valid_d = 1'b1;
            state_d = StStore;
          end
        end
        StStore: begin
          if (addr_q == MAX_ADDR) begin
            full_d  = 1'b1;
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StWaitHigh;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_bclk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      lrck_q  <= 1'b1;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lrck_q  <= i_adclrck;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  assign o_data      = data_q;
  assign o_address   = addr_q;
  assign o_valid     = valid_q;
  assign o_full      = full_q;
  assign o_recording = (state_q != StIdle);

endmodule
